// File: rtl/markov_merge_scheduler_pkg.sv
// Shared state encoding and default sizing for the Markov merge scheduler.
package markov_merge_scheduler_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    // Next round-robin index after idx, wrapping at n.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/markov_merge_scheduler_rr_pick.sv
// Rotating-priority picker: first set req bit at or above pointer, wrapping modulo NUM_REQ.
module markov_merge_scheduler_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int SEL_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   pointer,
    output logic [SEL_W-1:0]   winner,
    output logic               valid
);

    int               j;
    logic [SEL_W-1:0] idx;

    // Scan from the farthest offset down so the nearest set bit lands last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        j      = 0;
        idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j   = (int'(pointer) + i) % NUM_REQ;
            idx = SEL_W'(j);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/markov_merge_scheduler.sv
// Round-robin sequencer for the shared Markov merge engine: grant, start, watchdog wait, ack/err.
module markov_merge_scheduler
    import markov_merge_scheduler_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int SEL_W          = $clog2(NUM_REQ),
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [NUM_REQ-1:0] ack,
    output logic [NUM_REQ-1:0] err,
    output logic [SEL_W-1:0]   sel,
    output logic               merge_start,
    input  logic               merge_done,
    output logic               merge_abort,
    output logic               busy
);

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

    state_t           state;
    logic [SEL_W-1:0] pointer;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_valid;

    markov_merge_scheduler_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SEL_W   (SEL_W)
    ) u_rr_pick (
        .req     (req),
        .pointer (pointer),
        .winner  (pick_idx),
        .valid   (pick_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            pointer     <= '0;
            cnt         <= '0;
            gnt         <= '0;
            ack         <= '0;
            err         <= '0;
            sel         <= '0;
            merge_start <= 1'b0;
            merge_abort <= 1'b0;
            busy        <= 1'b0;
        end else begin
            merge_start <= 1'b0;
            merge_abort <= 1'b0;
            ack         <= '0;
            err         <= '0;
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        sel         <= pick_idx;
                        gnt         <= ONE << pick_idx;
                        merge_start <= 1'b1;
                        busy        <= 1'b1;
                        state       <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // cnt==0 marks the first WAIT cycle, where a stale done is masked.
                    if (merge_done && cnt != '0) begin
                        ack   <= gnt;
                        gnt   <= '0;
                        state <= S_RESP;
                    end else if (cnt == CNT_LAST) begin
                        err         <= gnt;
                        merge_abort <= 1'b1;
                        gnt         <= '0;
                        state       <= S_ABORT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP, S_ABORT: begin
                    pointer <= SEL_W'(wrap_inc(int'(sel), NUM_REQ));
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_markov_merge_scheduler.sv
// Directed bench for markov_merge_scheduler with NUM_REQ=4, TIMEOUT_CYCLES=8.
module tb_markov_merge_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] req = '0;
    logic       merge_done = 1'b0;
    logic [3:0] gnt, ack, err;
    logic [1:0] sel;
    logic       merge_start, merge_abort, busy;

    int tests = 0;
    int fails = 0;

    logic [3:0] a, e;
    logic       ab;

    markov_merge_scheduler #(.NUM_REQ(4), .TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .gnt         (gnt),
        .ack         (ack),
        .err         (err),
        .sel         (sel),
        .merge_start (merge_start),
        .merge_done  (merge_done),
        .merge_abort (merge_abort),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task step;
        @(posedge clk);
        #1;
    endtask

    task do_reset;
        reset = 1'b0;
        req = '0;
        merge_done = 1'b0;
        step;
        step;
        reset = 1'b1;
    endtask

    // From the ISSUE cycle: done is driven in WAIT cycle d; returns the RESP/ABORT-cycle outputs.
    task run_wait(input int d, output logic [3:0] a_o, output logic [3:0] e_o, output logic ab_o);
        step;
        for (int w = 1; w < d; w++) step;
        merge_done = 1'b1;
        step;
        a_o = ack;
        e_o = err;
        ab_o = merge_abort;
        merge_done = 1'b0;
    endtask

    task test_reset;
        reset = 1'b0;
        #2;
        tests++;
        if ({gnt, ack, err} !== 12'h000) begin
            fails++; $display("FAIL reset_vec: got %h want 000", {gnt, ack, err});
        end
        tests++;
        if ({sel, merge_start, merge_abort, busy} !== 5'b0) begin
            fails++; $display("FAIL reset_ctl: got %b want 00000", {sel, merge_start, merge_abort, busy});
        end
        step;
        reset = 1'b1;
    endtask

    task test_single;
        do_reset;
        req = 4'b0100;
        step;
        tests++;
        if (gnt !== 4'b0100 || sel !== 2'd2 || merge_start !== 1'b1) begin
            fails++; $display("FAIL single_grant: got gnt=%b sel=%0d start=%b want 0100/2/1", gnt, sel, merge_start);
        end
        step;
        tests++;
        if (merge_start !== 1'b0 || gnt !== 4'b0100) begin
            fails++; $display("FAIL single_start_pulse: got start=%b gnt=%b want 0/0100", merge_start, gnt);
        end
        for (int c = 3; c <= 6; c++) step;
        merge_done = 1'b1;
        step;
        tests++;
        if (ack !== 4'b0100 || gnt !== 4'b0000 || busy !== 1'b1) begin
            fails++; $display("FAIL single_ack: got ack=%b gnt=%b busy=%b want 0100/0000/1", ack, gnt, busy);
        end
        merge_done = 1'b0;
        req = '0;
        step;
        tests++;
        if (busy !== 1'b0 || ack !== 4'b0000) begin
            fails++; $display("FAIL single_idle: got busy=%b ack=%b want 0/0000", busy, ack);
        end
        req = 4'b1001;
        step;
        tests++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            fails++; $display("FAIL single_pointer3: got gnt=%b sel=%0d want 1000/3", gnt, sel);
        end
        run_wait(2, a, e, ab);
        req = '0;
        step;
    endtask

    task test_back_to_back;
        int         order [5];
        logic [3:0] oh;
        order = '{0, 1, 2, 3, 0};
        do_reset;
        req = 4'hF;
        for (int op = 0; op < 5; op++) begin
            step;
            oh = 4'b0001 << order[op];
            tests++;
            if (gnt !== oh || $countones(gnt) != 1) begin
                fails++; $display("FAIL b2b_gnt%0d: got %b want %b", op, gnt, oh);
            end
            run_wait(3, a, e, ab);
            tests++;
            if (a !== oh || e !== 4'b0000) begin
                fails++; $display("FAIL b2b_ack%0d: got ack=%b err=%b want %b/0000", op, a, e, oh);
            end
            step;
        end
        req = '0;
        step;
    endtask

    task test_stale_done;
        do_reset;
        req = 4'b0001;
        step;
        merge_done = 1'b1;
        step;
        step;
        tests++;
        if (ack !== 4'b0000 || gnt !== 4'b0001) begin
            fails++; $display("FAIL stale_masked: got ack=%b gnt=%b want 0000/0001", ack, gnt);
        end
        merge_done = 1'b0;
        step;
        step;
        tests++;
        if (ack !== 4'b0000 || busy !== 1'b1) begin
            fails++; $display("FAIL stale_wait4: got ack=%b busy=%b want 0000/1", ack, busy);
        end
        merge_done = 1'b1;
        step;
        tests++;
        if (ack !== 4'b0001) begin
            fails++; $display("FAIL stale_ack: got %b want 0001", ack);
        end
        merge_done = 1'b0;
        req = '0;
        step;
    endtask

    task test_timeout;
        logic early;
        do_reset;
        req = 4'b0010;
        step;
        early = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step;
            if (err !== 4'b0000 || merge_abort !== 1'b0 || ack !== 4'b0000) early = 1'b1;
        end
        tests++;
        if (early !== 1'b0) begin
            fails++; $display("FAIL timeout_early: got early=%b want 0", early);
        end
        step;
        tests++;
        if (err !== 4'b0010 || merge_abort !== 1'b1 || ack !== 4'b0000 || gnt !== 4'b0000) begin
            fails++; $display("FAIL timeout_err: got err=%b abort=%b ack=%b gnt=%b want 0010/1/0000/0000",
                              err, merge_abort, ack, gnt);
        end
        req = '0;
        step;
        tests++;
        if (busy !== 1'b0 || err !== 4'b0000 || merge_abort !== 1'b0) begin
            fails++; $display("FAIL timeout_idle: got busy=%b err=%b abort=%b want 0/0000/0", busy, err, merge_abort);
        end
        // Done in the last allowed WAIT cycle beats the watchdog.
        req = 4'b0010;
        step;
        run_wait(8, a, e, ab);
        tests++;
        if (a !== 4'b0010 || e !== 4'b0000 || ab !== 1'b0) begin
            fails++; $display("FAIL done_vs_timeout: got ack=%b err=%b abort=%b want 0010/0000/0", a, e, ab);
        end
        req = '0;
        step;
        merge_done = 1'b1;
        step;
        tests++;
        if (busy !== 1'b0 || ack !== 4'b0000 || gnt !== 4'b0000) begin
            fails++; $display("FAIL idle_done_ignored: got busy=%b ack=%b gnt=%b want 0/0000/0000", busy, ack, gnt);
        end
        merge_done = 1'b0;
    endtask

    task test_pointer_wrap;
        do_reset;
        req = 4'b1000;
        step;
        tests++;
        if (gnt !== 4'b1000) begin
            fails++; $display("FAIL wrap_first: got %b want 1000", gnt);
        end
        run_wait(2, a, e, ab);
        req = 4'b1001;
        step;
        step;
        tests++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            fails++; $display("FAIL wrap_to0: got gnt=%b sel=%0d want 0001/0", gnt, sel);
        end
        run_wait(2, a, e, ab);
        step;
        step;
        tests++;
        if (gnt !== 4'b1000 || sel !== 2'd3) begin
            fails++; $display("FAIL wrap_then3: got gnt=%b sel=%0d want 1000/3", gnt, sel);
        end
        run_wait(2, a, e, ab);
        req = '0;
        step;
    endtask

    task test_reset_mid;
        do_reset;
        req = 4'b0001;
        step;
        run_wait(2, a, e, ab);
        req = 4'b0100;
        step;
        step;
        tests++;
        if (gnt !== 4'b0100 || sel !== 2'd2) begin
            fails++; $display("FAIL rmid_grant: got gnt=%b sel=%0d want 0100/2", gnt, sel);
        end
        step;
        step;
        reset = 1'b0;
        #1;
        tests++;
        if (gnt !== 4'b0000 || busy !== 1'b0 || sel !== 2'd0) begin
            fails++; $display("FAIL rmid_async: got gnt=%b busy=%b sel=%0d want 0000/0/0", gnt, busy, sel);
        end
        req = 4'b0101;
        #2;
        reset = 1'b1;
        step;
        tests++;
        if (gnt !== 4'b0001 || sel !== 2'd0 || ack !== 4'b0000 || err !== 4'b0000) begin
            fails++; $display("FAIL rmid_regrant: got gnt=%b sel=%0d ack=%b err=%b want 0001/0/0000/0000",
                              gnt, sel, ack, err);
        end
        run_wait(2, a, e, ab);
        req = '0;
        step;
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_stale_done;
        test_timeout;
        test_pointer_wrap;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
